// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port definitions: memory mode codes, requester IDs and the pending-read tag.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_WIDTH_DEFAULT = 32;
   localparam int unsigned WORD_WIDTH_DEFAULT = 32;

   localparam logic [1:0] BYTE_MEMORY_MODE     = 2'b00;
   localparam logic [1:0] HALFWORD_MEMORY_MODE = 2'b01;
   localparam logic [1:0] WORD_MEMORY_MODE     = 2'b10;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

   typedef struct packed {
      logic       valid;
      logic       port;
      logic [1:0] unit;
      logic       sign_ext;
   } pend_tag_t;

   // Unit code 2'b11 is not a legal access size and never aligns.
   function automatic logic access_aligned(input logic [1:0] unit, input logic [1:0] lsb);
      logic ok;
      case (unit)
         BYTE_MEMORY_MODE:     ok = 1'b1;
         HALFWORD_MEMORY_MODE: ok = ~lsb[0];
         WORD_MEMORY_MODE:     ok = (lsb == 2'b00);
         default:              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero-extends a raw memory word according to the registered load size.
module mem_load_extend
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
   input  logic [1:0]            unit,
   input  logic                  sign_ext,
   input  logic [WORD_WIDTH-1:0] raw,
   output logic [WORD_WIDTH-1:0] ext
);

   always_comb begin
      ext = raw;
      case (unit)
         BYTE_MEMORY_MODE:     ext = {{(WORD_WIDTH-8){sign_ext & raw[7]}}, raw[7:0]};
         HALFWORD_MEMORY_MODE: ext = {{(WORD_WIDTH-16){sign_ext & raw[15]}}, raw[15:0]};
         default:              ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single synchronous memory port,
// with alignment checking and tagged, extended read-data return.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
   parameter int unsigned WORD_WIDTH   = WORD_WIDTH_DEFAULT,
   parameter int unsigned MAX_D_STREAK = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [WORD_WIDTH-1:0] if_rdata,
   output logic                  if_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [1:0]            d_unit,
   input  logic                  d_signed,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [WORD_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [WORD_WIDTH-1:0] d_rdata,
   output logic                  d_err,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [1:0]            mem_addr_unit,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [WORD_WIDTH-1:0] mem_data_in,
   input  logic [WORD_WIDTH-1:0] mem_data_out
);

   localparam int unsigned          STREAK_W   = $clog2(MAX_D_STREAK + 2);
   localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_D_STREAK);

   logic [STREAK_W-1:0] d_streak_q, d_streak_d;
   pend_tag_t           tag_q, tag_d;
   logic                if_pick, d_pick, if_ok, d_ok;
   logic [WORD_WIDTH-1:0] d_ext;

   always_comb begin
      // Grants are held off while in reset so the port looks idle.
      if_pick = rst_n & if_req & (~d_req | (d_streak_q == STREAK_MAX));
      d_pick  = rst_n & d_req & ~if_pick;
      if_ok   = (if_addr[1:0] == 2'b00);
      d_ok    = access_aligned(d_unit, d_addr[1:0]);

      if_gnt        = if_pick;
      if_err        = if_pick & ~if_ok;
      d_gnt         = d_pick;
      d_err         = d_pick & ~d_ok;

      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_addr_unit = 2'b00;
      mem_address   = '0;
      mem_data_in   = '0;
      tag_d         = '0;

      if (if_pick && if_ok) begin
         mem_read      = 1'b1;
         mem_addr_unit = WORD_MEMORY_MODE;
         mem_address   = if_addr;
         tag_d         = '{valid: 1'b1, port: PORT_IF, unit: WORD_MEMORY_MODE, sign_ext: 1'b0};
      end else if (d_pick && d_ok) begin
         mem_read      = ~d_we;
         mem_write     = d_we;
         mem_addr_unit = d_unit;
         mem_address   = d_addr;
         mem_data_in   = d_wdata;
         if (!d_we) begin
            tag_d = '{valid: 1'b1, port: PORT_D, unit: d_unit, sign_ext: d_signed};
         end
      end

      // Errored D grants still count towards the streak.
      d_streak_d = d_streak_q;
      if (!if_req || if_pick) begin
         d_streak_d = '0;
      end else if (d_pick && (d_streak_q != STREAK_MAX)) begin
         d_streak_d = d_streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_streak_q <= '0;
         tag_q      <= '0;
      end else begin
         d_streak_q <= d_streak_d;
         tag_q      <= tag_d;
      end
   end

   mem_load_extend #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_load_extend (
      .unit     (tag_q.unit),
      .sign_ext (tag_q.sign_ext),
      .raw      (mem_data_out),
      .ext      (d_ext)
   );

   always_comb begin
      if_rvalid = tag_q.valid & (tag_q.port == PORT_IF);
      d_rvalid  = tag_q.valid & (tag_q.port == PORT_D);
      if_rdata  = if_rvalid ? mem_data_out : '0;
      d_rdata   = d_rvalid ? d_ext : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural byte memory plus per-port
// expected-data queues consumed when rvalid appears.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned WW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid, if_err;
   logic [WW-1:0] if_rdata;
   logic          d_req, d_we, d_signed;
   logic [1:0]    d_unit;
   logic [AW-1:0] d_addr;
   logic [WW-1:0] d_wdata;
   logic          d_gnt, d_rvalid, d_err;
   logic [WW-1:0] d_rdata;
   logic          mem_read, mem_write;
   logic [1:0]    mem_addr_unit;
   logic [AW-1:0] mem_address;
   logic [WW-1:0] mem_data_in;
   logic [WW-1:0] mem_data_out;

   int checks = 0;
   int failures = 0;
   int both_cnt = 0;
   int zero_viol = 0;
   logic [31:0] if_q[$];
   logic [31:0] d_q[$];
   logic [31:0] if_words [3];

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_WIDTH   (AW),
      .WORD_WIDTH   (WW),
      .MAX_D_STREAK (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req        (if_req),
      .if_addr       (if_addr),
      .if_gnt        (if_gnt),
      .if_rvalid     (if_rvalid),
      .if_rdata      (if_rdata),
      .if_err        (if_err),
      .d_req         (d_req),
      .d_we          (d_we),
      .d_unit        (d_unit),
      .d_signed      (d_signed),
      .d_addr        (d_addr),
      .d_wdata       (d_wdata),
      .d_gnt         (d_gnt),
      .d_rvalid      (d_rvalid),
      .d_rdata       (d_rdata),
      .d_err         (d_err),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_addr_unit (mem_addr_unit),
      .mem_address   (mem_address),
      .mem_data_in   (mem_data_in),
      .mem_data_out  (mem_data_out)
   );

   // Byte memory; reads return the little-endian word starting at the address.
   logic [7:0]  mem [256];
   logic        pl_we = 1'b0;
   logic [7:0]  pl_addr;
   logic [31:0] pl_data;
   logic [7:0]  ma0, ma1, ma2, ma3;
   assign ma0 = mem_address[7:0];
   assign ma1 = ma0 + 8'd1;
   assign ma2 = ma0 + 8'd2;
   assign ma3 = ma0 + 8'd3;

   always @(posedge clk) begin
      if (pl_we) begin
         mem[pl_addr]        <= pl_data[7:0];
         mem[pl_addr + 8'd1] <= pl_data[15:8];
         mem[pl_addr + 8'd2] <= pl_data[23:16];
         mem[pl_addr + 8'd3] <= pl_data[31:24];
      end
      if (mem_write) begin
         mem[ma0] <= mem_data_in[7:0];
         if (mem_addr_unit != BYTE_MEMORY_MODE) mem[ma1] <= mem_data_in[15:8];
         if (mem_addr_unit == WORD_MEMORY_MODE) begin
            mem[ma2] <= mem_data_in[23:16];
            mem[ma3] <= mem_data_in[31:24];
         end
      end
      if (mem_read) mem_data_out <= {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
   end

   // Scoreboard consumer and always-on invariants.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_read && mem_write) both_cnt++;
         if (!if_rvalid && if_rdata !== '0) zero_viol++;
         if (!d_rvalid && d_rdata !== '0) zero_viol++;
         if (if_rvalid) begin
            checks++;
            if (if_q.size() == 0) begin
               failures++;
               $display("FAIL if_rvalid_unexpected: got rdata=%h, required no rvalid", if_rdata);
            end else begin
               logic [31:0] e;
               e = if_q.pop_front();
               if (if_rdata !== e) begin
                  failures++;
                  $display("FAIL if_rdata: got %h required %h", if_rdata, e);
               end
            end
         end
         if (d_rvalid) begin
            checks++;
            if (d_q.size() == 0) begin
               failures++;
               $display("FAIL d_rvalid_unexpected: got rdata=%h, required no rvalid", d_rdata);
            end else begin
               logic [31:0] e;
               e = d_q.pop_front();
               if (d_rdata !== e) begin
                  failures++;
                  $display("FAIL d_rdata: got %h required %h", d_rdata, e);
               end
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] w);
      pl_addr = a;
      pl_data = w;
      pl_we   = 1'b1;
      next_cycle();
      pl_we   = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_read, mem_write, mem_addr_unit,
           mem_address, mem_data_in, if_rdata, d_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got nonzero outputs, required all 0");
      end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, mem_address} !== '0) begin
         failures++;
         $display("FAIL idle_outputs: got nonzero outputs, required all 0");
      end
      // Fetch granted, then reset while its data is in flight.
      next_cycle();
      if_req  = 1'b1;
      if_addr = 32'h10;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || mem_read !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_gnt: got gnt=%b read=%b required 1 1", if_gnt, mem_read);
      end
      next_cycle();
      rst_n  = 1'b0;
      if_req = 1'b0;
      #1;
      checks++;
      if (if_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_rvalid: got %b required 0", if_rvalid);
      end
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_after_rvalid: got if=%b d=%b required 0 0", if_rvalid, d_rvalid);
         end
      end
   endtask

   task automatic test_if_back_to_back();
      next_cycle();
      if_req  = 1'b1;
      if_addr = 32'h00;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || if_rvalid !== 1'b0 || if_err !== 1'b0) begin
         failures++;
         $display("FAIL if_cycle1: got gnt=%b rvalid=%b err=%b required 1 0 0",
                  if_gnt, if_rvalid, if_err);
      end
      if_q.push_back(32'h0000_0013);
      next_cycle();
      if_addr = 32'h04;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || if_rvalid !== 1'b1) begin
         failures++;
         $display("FAIL if_cycle2: got gnt=%b rvalid=%b required 1 1", if_gnt, if_rvalid);
      end
      if_q.push_back(32'h0010_0093);
      next_cycle();
      if_req = 1'b0;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b0 || if_rvalid !== 1'b1) begin
         failures++;
         $display("FAIL if_cycle3: got gnt=%b rvalid=%b required 0 1", if_gnt, if_rvalid);
      end
      next_cycle();
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  unit;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } d_op_t;

   task automatic test_store_load();
      d_op_t ops[$];
      ops.push_back('{1'b1, BYTE_MEMORY_MODE,     1'b0, 32'h21, 32'h1234_56AB, 32'h0});
      ops.push_back('{1'b0, BYTE_MEMORY_MODE,     1'b1, 32'h21, 32'h0,         32'hFFFF_FFAB});
      ops.push_back('{1'b0, BYTE_MEMORY_MODE,     1'b0, 32'h21, 32'h0,         32'h0000_00AB});
      ops.push_back('{1'b1, HALFWORD_MEMORY_MODE, 1'b0, 32'h20, 32'hCAFE_8001, 32'h0});
      ops.push_back('{1'b0, HALFWORD_MEMORY_MODE, 1'b1, 32'h20, 32'h0,         32'hFFFF_8001});
      ops.push_back('{1'b0, WORD_MEMORY_MODE,     1'b1, 32'h20, 32'h0,         32'h5566_8001});
      // Store right behind a load: the load's data must be the pre-store value.
      ops.push_back('{1'b1, WORD_MEMORY_MODE,     1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0});
      ops.push_back('{1'b0, WORD_MEMORY_MODE,     1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF});
      ops.push_back('{1'b0, HALFWORD_MEMORY_MODE, 1'b0, 32'h22, 32'h0,         32'h0000_DEAD});
      foreach (ops[i]) begin
         next_cycle();
         d_req    = 1'b1;
         d_we     = ops[i].we;
         d_unit   = ops[i].unit;
         d_signed = ops[i].sgn;
         d_addr   = ops[i].addr;
         d_wdata  = ops[i].wdata;
         @(negedge clk);
         checks++;
         if (d_gnt !== 1'b1 || d_err !== 1'b0 || mem_write !== ops[i].we ||
             mem_read !== !ops[i].we || mem_address !== ops[i].addr ||
             mem_addr_unit !== ops[i].unit || (ops[i].we && mem_data_in !== ops[i].wdata)) begin
            failures++;
            $display("FAIL d_op%0d_cmd: got gnt=%b err=%b rd=%b wr=%b addr=%h unit=%b din=%h required gnt=1 err=0 wr=%b addr=%h",
                     i, d_gnt, d_err, mem_read, mem_write, mem_address, mem_addr_unit,
                     mem_data_in, ops[i].we, ops[i].addr);
         end
         if (!ops[i].we) d_q.push_back(ops[i].exp);
      end
      next_cycle();
      d_req = 1'b0;
      repeat (2) next_cycle();
   endtask

   task automatic test_arbitration();
      logic [10:0] ifr_pat;
      logic [10:0] ifg_pat;
      int ii = 0;
      int di = 0;
      ifr_pat = 11'b111_0111_1111;
      ifg_pat = 11'b100_0010_0100;
      for (int k = 0; k < 11; k++) begin
         next_cycle();
         if_req   = ifr_pat[k];
         if_addr  = 32'(ii * 4);
         d_req    = 1'b1;
         d_we     = 1'b0;
         d_unit   = WORD_MEMORY_MODE;
         d_signed = 1'b0;
         d_addr   = 32'h40 + 32'(di * 4);
         @(negedge clk);
         checks++;
         if (if_gnt !== ifg_pat[k] || d_gnt !== !ifg_pat[k]) begin
            failures++;
            $display("FAIL arb_cycle%0d: got if_gnt=%b d_gnt=%b required %b %b",
                     k, if_gnt, d_gnt, ifg_pat[k], !ifg_pat[k]);
         end
         if (ifg_pat[k]) begin
            if_q.push_back(if_words[ii]);
            ii++;
         end else begin
            d_q.push_back(32'hA000_0000 | d_addr);
            di++;
         end
      end
      next_cycle();
      if_req = 1'b0;
      d_req  = 1'b0;
      repeat (2) next_cycle();
   endtask

   task automatic test_misaligned();
      d_op_t ops[$];
      ops.push_back('{1'b0, WORD_MEMORY_MODE,     1'b0, 32'h22, 32'h0, 32'h0});
      ops.push_back('{1'b0, HALFWORD_MEMORY_MODE, 1'b1, 32'h21, 32'h0, 32'h0});
      ops.push_back('{1'b0, 2'b11,                1'b0, 32'h20, 32'h0, 32'h0});
      ops.push_back('{1'b1, WORD_MEMORY_MODE,     1'b0, 32'h21, 32'h5, 32'h0});
      foreach (ops[i]) begin
         next_cycle();
         d_req    = 1'b1;
         d_we     = ops[i].we;
         d_unit   = ops[i].unit;
         d_signed = ops[i].sgn;
         d_addr   = ops[i].addr;
         d_wdata  = ops[i].wdata;
         @(negedge clk);
         checks++;
         if (d_gnt !== 1'b1 || d_err !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL d_misalign%0d: got gnt=%b err=%b rd=%b wr=%b required 1 1 0 0",
                     i, d_gnt, d_err, mem_read, mem_write);
         end
      end
      next_cycle();
      d_req   = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h06;
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || if_err !== 1'b1 || mem_read !== 1'b0) begin
         failures++;
         $display("FAIL if_misalign: got gnt=%b err=%b rd=%b required 1 1 0",
                  if_gnt, if_err, mem_read);
      end
      next_cycle();
      if_req = 1'b0;
      repeat (3) next_cycle();
   endtask

   task automatic test_invariants();
      checks++;
      if (both_cnt != 0) begin
         failures++;
         $display("FAIL read_write_overlap: got %0d cycles required 0", both_cnt);
      end
      checks++;
      if (zero_viol != 0) begin
         failures++;
         $display("FAIL rdata_zero_when_idle: got %0d violations required 0", zero_viol);
      end
      checks++;
      if (if_q.size() != 0 || d_q.size() != 0) begin
         failures++;
         $display("FAIL missing_rvalid: got if=%0d d=%0d outstanding required 0 0",
                  if_q.size(), d_q.size());
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      if_req   = 1'b0;
      if_addr  = '0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_unit   = 2'b00;
      d_signed = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      if_words[0] = 32'h0000_0013;
      if_words[1] = 32'h0010_0093;
      if_words[2] = 32'h0020_0113;
      #1;
      preload(8'h00, if_words[0]);
      preload(8'h04, if_words[1]);
      preload(8'h08, if_words[2]);
      preload(8'h10, 32'h0BAD_0BAD);
      preload(8'h20, 32'h5566_7788);
      preload(8'h24, 32'h99AA_BBCC);
      for (int k = 0; k < 8; k++) preload(8'h40 + 8'(k * 4), 32'hA000_0040 + 32'(k * 4));
      test_reset();
      test_if_back_to_back();
      test_store_load();
      test_arbitration();
      test_misaligned();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
